// File: rtl/register_file_sb_if.sv
// Decode-stage register file bus: read ports, write-back ports, scoreboard alloc and dump stream.
interface register_file_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  rs_busy;
  logic                  rt_busy;
  logic                  wr_en0;
  logic [ADDR_WIDTH-1:0] wr_addr0;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic                  wr_en1;
  logic [ADDR_WIDTH-1:0] wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic                  alloc_en;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  dump_start;
  logic                  dump_valid;
  logic [ADDR_WIDTH-1:0] dump_idx;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_active;

  modport master (
    output rs_addr, rt_addr, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, alloc_en, alloc_addr, dump_start,
    input  rs_data, rt_data, rs_busy, rt_busy,
           dump_valid, dump_idx, dump_data, dump_active
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en0, wr_addr0, wr_data0,
           wr_en1, wr_addr1, wr_data1, alloc_en, alloc_addr, dump_start,
    output rs_data, rt_data, rs_busy, rt_busy,
           dump_valid, dump_idx, dump_data, dump_active
  );
endinterface

// File: rtl/register_file_sb.sv
// Two-read / two-write register file with write bypass, busy scoreboard and dump sequencer.
module register_file_sb #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter bit                    ZERO_REG   = 1'b1,
  parameter int unsigned           SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h8012_0000)
) (
  input logic               clk,
  input logic               reset,
  register_file_sb_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  we0_c, we1_c, alloc_c;

  logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic                  rs_busy_q, rs_busy_d, rt_busy_q, rt_busy_d;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  dump_valid_q, dump_valid_d, dump_active_q, dump_active_d;
  logic [ADDR_WIDTH-1:0] dump_idx_q, dump_idx_d;
  logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;

  // Value a register holds after this edge's writes: port 1, then port 0, then the array.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] arr,
    input logic                  e0,
    input logic [ADDR_WIDTH-1:0] a0,
    input logic [DATA_WIDTH-1:0] d0,
    input logic                  e1,
    input logic [ADDR_WIDTH-1:0] a1,
    input logic [DATA_WIDTH-1:0] d1
  );
    logic [DATA_WIDTH-1:0] v;
    v = arr;
    if (e0 && (a0 == a)) v = d0;
    if (e1 && (a1 == a)) v = d1;
    return v;
  endfunction

  // Effective write/alloc strobes; the hardwired zero register swallows them.
  always_comb begin
    we0_c   = bus.wr_en0   && !(ZERO_REG && (bus.wr_addr0   == '0));
    we1_c   = bus.wr_en1   && !(ZERO_REG && (bus.wr_addr1   == '0));
    alloc_c = bus.alloc_en && !(ZERO_REG && (bus.alloc_addr == '0));
  end

  // Register array: reset preset, then port 0 and port 1 writes (port 1 lands last).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_INIT : DATA_WIDTH'(i);
      end
    end else begin
      if (we0_c) regs_q[bus.wr_addr0] <= bus.wr_data0;
      if (we1_c) regs_q[bus.wr_addr1] <= bus.wr_data1;
    end
  end

  // Scoreboard next state: writes retire a producer, a same-edge alloc re-marks it busy.
  always_comb begin
    busy_d = busy_q;
    if (we0_c)   busy_d[bus.wr_addr0]   = 1'b0;
    if (we1_c)   busy_d[bus.wr_addr1]   = 1'b0;
    if (alloc_c) busy_d[bus.alloc_addr] = 1'b1;
  end

  // Read port next values, bypassing this edge's writes and scoreboard update.
  always_comb begin
    rs_data_d = fwd(bus.rs_addr, regs_q[bus.rs_addr], we0_c, bus.wr_addr0, bus.wr_data0,
                    we1_c, bus.wr_addr1, bus.wr_data1);
    rt_data_d = fwd(bus.rt_addr, regs_q[bus.rt_addr], we0_c, bus.wr_addr0, bus.wr_data0,
                    we1_c, bus.wr_addr1, bus.wr_data1);
    rs_busy_d = busy_d[bus.rs_addr];
    rt_busy_d = busy_d[bus.rt_addr];
  end

  // Scoreboard and read port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_busy_q <= 1'b0;
      rt_busy_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_busy_q <= rs_busy_d;
      rt_busy_q <= rt_busy_d;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dump FSM next state: start only from IDLE, walk every index once, then return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.dump_start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dump FSM outputs: one register per RUN cycle, with the same bypass as the read ports.
  always_comb begin
    dump_valid_d  = 1'b0;
    dump_active_d = 1'b0;
    dump_idx_d    = '0;
    dump_data_d   = '0;
    if (state_q == ST_RUN) begin
      dump_valid_d  = 1'b1;
      dump_active_d = 1'b1;
      dump_idx_d    = cnt_q;
      dump_data_d   = fwd(cnt_q, regs_q[cnt_q], we0_c, bus.wr_addr0, bus.wr_data0,
                          we1_c, bus.wr_addr1, bus.wr_data1);
    end
  end

  // Dump output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_valid_q  <= 1'b0;
      dump_active_q <= 1'b0;
      dump_idx_q    <= '0;
      dump_data_q   <= '0;
    end else begin
      dump_valid_q  <= dump_valid_d;
      dump_active_q <= dump_active_d;
      dump_idx_q    <= dump_idx_d;
      dump_data_q   <= dump_data_d;
    end
  end

  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.rs_busy     = rs_busy_q;
  assign bus.rt_busy     = rt_busy_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_idx    = dump_idx_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.dump_active = dump_active_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: one DUT with a hardwired zero register, one without, same stimulus.
module tb_register_file_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam logic [31:0] SP = 32'h8012_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr0, wr_addr1, alloc_addr;
  logic [DW-1:0] wr_data0, wr_data1;
  logic          wr_en0, wr_en1, alloc_en, dump_start;

  int vectors = 0;
  int errors  = 0;

  register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_z ();
  register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();

  assign bus_z.rs_addr = rs_addr;     assign bus_n.rs_addr = rs_addr;
  assign bus_z.rt_addr = rt_addr;     assign bus_n.rt_addr = rt_addr;
  assign bus_z.wr_en0 = wr_en0;       assign bus_n.wr_en0 = wr_en0;
  assign bus_z.wr_addr0 = wr_addr0;   assign bus_n.wr_addr0 = wr_addr0;
  assign bus_z.wr_data0 = wr_data0;   assign bus_n.wr_data0 = wr_data0;
  assign bus_z.wr_en1 = wr_en1;       assign bus_n.wr_en1 = wr_en1;
  assign bus_z.wr_addr1 = wr_addr1;   assign bus_n.wr_addr1 = wr_addr1;
  assign bus_z.wr_data1 = wr_data1;   assign bus_n.wr_data1 = wr_data1;
  assign bus_z.alloc_en = alloc_en;   assign bus_n.alloc_en = alloc_en;
  assign bus_z.alloc_addr = alloc_addr; assign bus_n.alloc_addr = alloc_addr;
  assign bus_z.dump_start = dump_start; assign bus_n.dump_start = dump_start;

  register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .ZERO_REG(1'b1),
                     .SP_INDEX(29), .SP_INIT(SP))
    dut_z (.clk(clk), .reset(reset), .bus(bus_z));

  register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .ZERO_REG(1'b0),
                     .SP_INDEX(29), .SP_INIT(SP))
    dut_n (.clk(clk), .reset(reset), .bus(bus_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = zero register hardwired, index 1 = ordinary register 0.
  logic [31:0] m_reg  [2][NR];
  logic        m_busy [2][NR];
  logic        m_run  [2];
  int          m_cnt  [2];
  logic [31:0] e_rsd [2], e_rtd [2], e_dd [2];
  logic        e_rsb [2], e_rtb [2], e_dv [2];
  logic [AW-1:0] e_di [2];
  bit          model_live = 1'b0;

  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int i = 0; i < NR; i++) begin
          m_reg[m][i]  = (i == 29) ? SP : 32'(i);
          m_busy[m][i] = 1'b0;
        end
        m_run[m] = 1'b0; m_cnt[m] = 0;
        e_rsd[m] = '0; e_rtd[m] = '0; e_rsb[m] = 1'b0; e_rtb[m] = 1'b0;
        e_dv[m] = 1'b0; e_di[m] = '0; e_dd[m] = '0;
      end else begin
        if (wr_en0 && !(m == 0 && wr_addr0 == 0)) begin
          m_reg[m][wr_addr0] = wr_data0; m_busy[m][wr_addr0] = 1'b0;
        end
        if (wr_en1 && !(m == 0 && wr_addr1 == 0)) begin
          m_reg[m][wr_addr1] = wr_data1; m_busy[m][wr_addr1] = 1'b0;
        end
        if (alloc_en && !(m == 0 && alloc_addr == 0)) m_busy[m][alloc_addr] = 1'b1;
        e_rsd[m] = m_reg[m][rs_addr];  e_rtd[m] = m_reg[m][rt_addr];
        e_rsb[m] = m_busy[m][rs_addr]; e_rtb[m] = m_busy[m][rt_addr];
        e_dv[m] = m_run[m];
        if (m_run[m]) begin
          e_di[m] = AW'(m_cnt[m]);
          e_dd[m] = m_reg[m][m_cnt[m]];
          m_cnt[m]++;
          if (m_cnt[m] == NR) m_run[m] = 1'b0;
        end else if (dump_start) begin
          m_run[m] = 1'b1; m_cnt[m] = 0;
        end
      end
    end
    if (reset) model_live = 1'b1;
  endfunction

  task automatic cmp_mode(input int m, input string p,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic rsb, input logic rtb, input logic dv,
                          input logic [AW-1:0] di, input logic [31:0] dd, input logic da);
    chk({p, " rs_data"}, rsd, e_rsd[m]);
    chk({p, " rt_data"}, rtd, e_rtd[m]);
    chk({p, " rs_busy"}, 32'(rsb), 32'(e_rsb[m]));
    chk({p, " rt_busy"}, 32'(rtb), 32'(e_rtb[m]));
    chk({p, " dump_valid"}, 32'(dv), 32'(e_dv[m]));
    chk({p, " dump_active"}, 32'(da), 32'(e_dv[m]));
    if (e_dv[m]) begin
      chk({p, " dump_idx"}, 32'(di), 32'(e_di[m]));
      chk({p, " dump_data"}, dd, e_dd[m]);
    end
  endtask

  // Compare process: advance the model on each edge, check both DUTs just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    if (model_live) begin
      cmp_mode(0, "z", bus_z.rs_data, bus_z.rt_data, bus_z.rs_busy, bus_z.rt_busy,
               bus_z.dump_valid, bus_z.dump_idx, bus_z.dump_data, bus_z.dump_active);
      cmp_mode(1, "n", bus_n.rs_data, bus_n.rt_data, bus_n.rs_busy, bus_n.rt_busy,
               bus_n.dump_valid, bus_n.dump_idx, bus_n.dump_data, bus_n.dump_active);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    wr_en0 = 1'b0; wr_en1 = 1'b0; alloc_en = 1'b0; dump_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    int n;
    bit seen;
    logic [31:0] exp_d;
    reset = 1'b1; rs_addr = '0; rt_addr = '0;
    wr_addr0 = '0; wr_addr1 = '0; alloc_addr = '0; wr_data0 = '0; wr_data1 = '0;
    quiet();
    cyc(); cyc();
    chk("reset rs_data", bus_z.rs_data, 32'h0);
    chk("reset dump_active", 32'(bus_z.dump_active), 32'h0);

    // Reset contents, including the stack pointer preset.
    reset = 1'b0; rs_addr = 5'd5; rt_addr = 5'd29;
    cyc();
    chk("t1 rs_data", bus_z.rs_data, 32'd5);
    chk("t1 rt_data", bus_z.rt_data, SP);
    chk("t1 rs_busy", 32'(bus_z.rs_busy), 32'h0);
    chk("t1 rt_busy", 32'(bus_z.rt_busy), 32'h0);

    // Same-address double write: port 1 wins, both bypassed and stored.
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'd100;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'd200; rs_addr = 5'd7;
    cyc();
    chk("t2 bypass", bus_z.rs_data, 32'd200);
    quiet(); cyc(); cyc();
    chk("t2 stored", bus_z.rs_data, 32'd200);

    // Register 0: hardwired in one DUT, ordinary in the other.
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'd55;
    alloc_en = 1'b1; alloc_addr = 5'd0; rs_addr = 5'd0;
    cyc();
    chk("t3 z rs_data", bus_z.rs_data, 32'h0);
    chk("t3 z rs_busy", 32'(bus_z.rs_busy), 32'h0);
    chk("t3 n rs_data", bus_n.rs_data, 32'd55);
    chk("t3 n rs_busy", 32'(bus_n.rs_busy), 32'h1);
    quiet();

    // Scoreboard: alloc, write+alloc same edge, then write alone.
    alloc_en = 1'b1; alloc_addr = 5'd12; rs_addr = 5'd12;
    cyc();
    chk("t4 alloc busy", 32'(bus_z.rs_busy), 32'h1);
    wr_en0 = 1'b1; wr_addr0 = 5'd12; wr_data0 = 32'h1234;
    cyc();
    chk("t4 wr+alloc busy", 32'(bus_z.rs_busy), 32'h1);
    chk("t4 wr+alloc data", bus_z.rs_data, 32'h1234);
    quiet(); wr_en1 = 1'b1; wr_addr1 = 5'd12; wr_data1 = 32'h5678;
    cyc();
    chk("t4 retire busy", 32'(bus_z.rs_busy), 32'h0);
    chk("t4 retire data", bus_z.rs_data, 32'h5678);
    quiet(); cyc();
    chk("t4 hold data", bus_n.rs_data, 32'h5678);

    // Full dump after reset with a mid-dump write and an ignored restart.
    reset = 1'b1; cyc(); reset = 1'b0;
    dump_start = 1'b1; cyc(); dump_start = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      quiet();
      if (bus_z.dump_valid) begin
        exp_d = (n == 29) ? SP : (n == 20) ? 32'd999 : 32'(n);
        chk("t5 dump_idx", 32'(bus_z.dump_idx), 32'(n));
        chk("t5 dump_data", bus_z.dump_data, exp_d);
        if (bus_z.dump_idx == 5'd10) begin
          wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 32'd999;
        end
        if (bus_z.dump_idx == 5'd5) dump_start = 1'b1;
        n++;
      end
    end
    chk("t5 dump_count", 32'(n), 32'd32);
    chk("t5 active after", 32'(bus_z.dump_active), 32'h0);

    // Reset in the middle of a dump with busy bits set.
    quiet();
    alloc_en = 1'b1; alloc_addr = 5'd3; cyc();
    alloc_addr = 5'd9; cyc();
    alloc_en = 1'b0; rs_addr = 5'd3; rt_addr = 5'd9; dump_start = 1'b1;
    cyc();
    chk("t6 busy rs", 32'(bus_z.rs_busy), 32'h1);
    chk("t6 busy rt", 32'(bus_z.rt_busy), 32'h1);
    dump_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cyc();
      if (bus_z.dump_valid && bus_z.dump_idx == 5'd15) seen = 1'b1;
    end
    chk("t6 reached idx15", 32'(seen), 32'h1);
    reset = 1'b1; cyc();
    chk("t6 dump_valid", 32'(bus_z.dump_valid), 32'h0);
    chk("t6 dump_active", 32'(bus_z.dump_active), 32'h0);
    reset = 1'b0; cyc();
    chk("t6 rs busy cleared", 32'(bus_z.rs_busy), 32'h0);
    chk("t6 rt busy cleared", 32'(bus_n.rt_busy), 32'h0);
    chk("t6 rs data", bus_z.rs_data, 32'd3);
    rs_addr = 5'd20; rt_addr = 5'd7; cyc();
    chk("t6 reg20 restored", bus_z.rs_data, 32'd20);
    chk("t6 reg7 restored", bus_n.rt_data, 32'd7);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (bus_z.dump_valid || bus_n.dump_valid) n++;
    end
    chk("t6 no stray dump", 32'(n), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-write-port decode-stage register file.
- Provides two synchronous read ports with write-to-read bypass and two write-back ports (port 1 has priority).
- Adds a per-register busy scoreboard for hazard detection, plus a hardware dump sequencer that replaces simulation-only register printing.
- Instantiated in the decode stage; write ports are driven by the writeback stage.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, number of architectural registers; power of two, minimum 4
ADDR_WIDTH, 5, log2(NUM_REGS)
ZERO_REG, 1, 1: register 0 reads 0 and ignores writes/allocs; 0: register 0 is ordinary
SP_INDEX, 29, register preset to SP_INIT at reset
SP_INIT, 32'h80120000, stack pointer reset value (32'h80020000 + 1 MB)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
rs_addr  in  ADDR_WIDTH  read port A address
rt_addr  in  ADDR_WIDTH  read port B address
rs_data  out  DATA_WIDTH  read port A data, registered
rt_data  out  DATA_WIDTH  read port B data, registered
rs_busy  out  1  busy bit of rs_addr, registered alongside rs_data
rt_busy  out  1  busy bit of rt_addr, registered alongside rt_data
wr_en0  in  1  write port 0 enable
wr_addr0  in  ADDR_WIDTH  write port 0 address
wr_data0  in  DATA_WIDTH  write port 0 data
wr_en1  in  1  write port 1 enable (priority port)
wr_addr1  in  ADDR_WIDTH  write port 1 address
wr_data1  in  DATA_WIDTH  write port 1 data
alloc_en  in  1  mark alloc_addr as having an in-flight producer
alloc_addr  in  ADDR_WIDTH  register to mark busy
dump_start  in  1  one-cycle pulse starting a full register dump
dump_valid  out  1  dump_idx/dump_data valid this cycle
dump_idx  out  ADDR_WIDTH  index of the register being dumped
dump_data  out  DATA_WIDTH  contents of register dump_idx
dump_active  out  1  high while the dump sequencer is running

Behaviour:
- Reset (synchronous, takes precedence over every other input in that cycle):
  - reg[i] = i, truncated to DATA_WIDTH; reg[SP_INDEX] = SP_INIT.
  - All busy bits = 0; FSM = IDLE.
  - rs_data, rt_data, rs_busy, rt_busy, dump_valid, dump_idx, dump_data, dump_active all = 0.
- Writes: committed at the rising edge.
  - If wr_en0 and wr_en1 target the same address, wr_data1 is stored.
  - When ZERO_REG=1, writes to address 0 are dropped silently.
- Reads: latency 1; rs_data(t+1) is the value of reg[rs_addr] after the cycle-t writes.
  - Bypass order: port 1 match, then port 0 match, then array contents.
  - When ZERO_REG=1, address 0 always returns 0 and busy 0.
  - Same rules apply to port B.
- Scoreboard, evaluated per edge:
  - A write on either port to address a clears busy[a].
  - alloc_en sets busy[alloc_addr].
  - If alloc and write hit the same address in the same cycle, busy is set (the newer producer wins).
  - Alloc to address 0 is ignored when ZERO_REG=1.
  - rs_busy/rt_busy sample busy after that edge's update, using the same bypass order as the data.
- Dump FSM: states IDLE, RUN.
  - IDLE: dump_start moves to RUN with the counter at 0; dump_active is asserted the next cycle.
  - RUN: each cycle dump_valid=1, dump_idx=counter, dump_data = reg[counter] with the same write bypass as the read ports; the counter then increments.
  - RUN ends after index NUM_REGS-1 and returns to IDLE: dump_valid=0 and dump_active=0 on the following cycle.
  - A dump takes exactly NUM_REGS valid cycles, indices strictly ascending with no gaps.
  - dump_start while in RUN is ignored.
  - Normal reads and writes continue unaffected during a dump.
  - Reset mid-dump forces IDLE at once; no further dump_valid pulses are produced.
- No X-filtering of write data; the writer guarantees that wr_data is valid whenever wr_en is set.

Test Plan:
1. Reset, then read rs=5, rt=29 -> after 1 cycle rs_data=5, rt_data=32'h80120000, rs_busy=rt_busy=0.
2. In the same cycle, wr_en0 addr 7 data 100, wr_en1 addr 7 data 200, rs_addr=7 -> next cycle rs_data=200; a later read of 7 also returns 200.
3. Write addr 0 data 55 and alloc addr 0, read rs=0 -> rs_data=0, rs_busy=0; repeat with ZERO_REG=0 -> rs_data=55, rs_busy=1.
4. Alloc 12 -> rs_busy=1 on reads of 12. Then write 12 and alloc 12 in the same cycle -> still busy. Then write 12 alone -> rs_busy=0 and the data matches the last write.
5. Pulse dump_start with NUM_REGS=32 after reset -> 32 consecutive dump_valid cycles, dump_idx 0..31, dump_data=i except idx 29=32'h80120000. A write of 999 to reg 20 while idx=10 -> idx 20 shows 999. A second dump_start mid-dump -> ignored.
6. Assert reset while dump_idx=15 with busy bits set -> the next cycle shows dump_valid=0, dump_active=0, all busy bits cleared, and registers restored to their reset values.
